// File: rtl/msk_unshare_serial.sv
// msk_unshare_serial: serial recombination of a D-share Boolean sharing.
// The sharing is captured into a register in IDLE; FOLD then XORs one share
// per cycle into an accumulator, so no logic cone ever combines all shares
// at once. HOLD presents the unmasked value until the consumer accepts it.
// Optional build macro MSKUNSHARE_ZEROIZE_EN: clears the share register when
// folding ends, and clears the accumulator/output on the output handshake.
module msk_unshare_serial #(
    parameter int D = 2,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [D*W-1:0] in_sh,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);

    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam int NS = 1 << CW;
    localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FOLD = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [D*W-1:0] sreg_q, sreg_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;

    logic [W-1:0]   shares [NS];
    logic [W-1:0]   share_sel;
    logic [W-1:0]   fold_val;

    // Regroup the bit-major share register into one word per share index;
    // unused slots beyond D are tied to zero so the select never goes wild.
    always_comb begin
        for (int j = 0; j < NS; j++) begin
            shares[j] = '0;
        end
        for (int j = 0; j < D; j++) begin
            for (int i = 0; i < W; i++) begin
                shares[j][i] = sreg_q[i*D + j];
            end
        end
        share_sel = shares[cnt_q];
    end

    // Next-state logic: capture, fold one share per cycle, hold until accepted.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        fold_val    = (cnt_q == '0) ? share_sel : (acc_q ^ share_sel);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sreg_d  = in_sh;
                    cnt_d   = '0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                acc_d = fold_val;
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    out_data_d  = fold_val;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
`ifdef MSKUNSHARE_ZEROIZE_EN
                    sreg_d      = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef MSKUNSHARE_ZEROIZE_EN
                    acc_d       = '0;
                    out_data_d  = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sreg_q      <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_msk_unshare_serial.sv
// Bench for msk_unshare_serial: a D=2 and a D=3 instance side by side.
// Honours MSKUNSHARE_ZEROIZE_EN when checking post-handshake register contents.
module tb_msk_unshare_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic [15:0] in_sh2;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [7:0]  out_data2;

    logic [23:0] in_sh3;
    logic        in_valid3, in_ready3, out_valid3, out_ready3, busy3;
    logic [7:0]  out_data3;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    logic [7:0] q2 [$];
    logic [7:0] q3 [$];

    msk_unshare_serial #(.D(2), .W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .in_sh(in_sh2), .in_valid(in_valid2),
        .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .busy(busy2)
    );

    msk_unshare_serial #(.D(3), .W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .in_sh(in_sh3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .busy(busy3)
    );

    // Free-running edge counter used to measure accept spacing.
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [15:0] pack2(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            v[i*2+0] = a[i];
            v[i*2+1] = b[i];
        end
        return v;
    endfunction

    function automatic logic [23:0] pack3(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
        logic [23:0] v;
        for (int i = 0; i < 8; i++) begin
            v[i*3+0] = a[i];
            v[i*3+1] = b[i];
            v[i*3+2] = c[i];
        end
        return v;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, present a sharing, return after the accept edge.
    task automatic applyStimulus(input bit to3, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [7:0] exp,
                                 input bit push, output int acc_cycle);
        int guard = 0;
        while (!(to3 ? in_ready3 : in_ready2) && guard < 50) begin
            stepCycle();
            guard++;
        end
        if (guard >= 50) checkOutput("in_ready wait timeout", {31'd0, to3 ? in_ready3 : in_ready2}, 1);
        if (to3) begin
            in_sh3    = pack3(a, b, c);
            in_valid3 = 1'b1;
            if (push) q3.push_back(exp);
        end else begin
            in_sh2    = pack2(a, b);
            in_valid2 = 1'b1;
            if (push) q2.push_back(exp);
        end
        stepCycle();
        acc_cycle = cycle;
    endtask

    // Output monitors pop the expected value at every output handshake.
    always @(negedge clk) begin
        logic [7:0] e;
        if (out_valid2 === 1'b1 && out_ready2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL dut2 unexpected output: got 0x%0h, expected none", out_data2);
            end else begin
                e = q2.pop_front();
                checkOutput("dut2 scoreboard out_data", {24'd0, out_data2}, {24'd0, e});
            end
        end
        if (out_valid3 === 1'b1 && out_ready3 === 1'b1) begin
            if (q3.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL dut3 unexpected output: got 0x%0h, expected none", out_data3);
            end else begin
                e = q3.pop_front();
                checkOutput("dut3 scoreboard out_data", {24'd0, out_data3}, {24'd0, e});
            end
        end
    end

    logic [7:0] va [4] = '{8'h12, 8'hAA, 8'h81, 8'h3C};
    logic [7:0] vb [4] = '{8'h34, 8'h55, 8'h18, 8'h0F};
    logic [7:0] ve [4] = '{8'h26, 8'hFF, 8'h99, 8'h33};

    initial begin
        int t;
        int prev;
        int guard;

        rst_n = 1'b0;
        in_sh2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;
        in_sh3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;

        // Reset values
        stepCycle();
        checkOutput("reset in_ready2", {31'd0, in_ready2}, 0);
        checkOutput("reset in_ready3", {31'd0, in_ready3}, 0);
        checkOutput("reset out_valid2", {31'd0, out_valid2}, 0);
        checkOutput("reset out_data2", {24'd0, out_data2}, 0);
        checkOutput("reset busy2", {31'd0, busy2}, 0);
        checkOutput("reset out_valid3", {31'd0, out_valid3}, 0);
        checkOutput("reset out_data3", {24'd0, out_data3}, 0);
        stepCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("post-reset in_ready2", {31'd0, in_ready2}, 1);

        // D=2: (0x5A, 0xC3) -> 0x99 two cycles after accept
        applyStimulus(1'b0, 8'h5A, 8'hC3, 8'h00, 8'h99, 1'b1, t);
        in_valid2 = 1'b0;
        checkOutput("d2 busy after accept", {31'd0, busy2}, 1);
        checkOutput("d2 in_ready after accept", {31'd0, in_ready2}, 0);
        checkOutput("d2 out_valid at t", {31'd0, out_valid2}, 0);
        stepCycle();
        checkOutput("d2 out_valid at t+1", {31'd0, out_valid2}, 0);
        stepCycle();
        checkOutput("d2 out_valid at t+2", {31'd0, out_valid2}, 1);
        checkOutput("d2 out_data at t+2", {24'd0, out_data2}, 32'h99);

        // HOLD with out_ready low for 5 cycles; a pulsed input must be ignored
        for (int k = 0; k < 5; k++) begin
            in_valid2 = (k == 2);
            if (k == 2) in_sh2 = pack2(8'hFF, 8'h00);
            checkOutput("d2 hold in_ready", {31'd0, in_ready2}, 0);
            stepCycle();
            checkOutput("d2 hold out_valid", {31'd0, out_valid2}, 1);
            checkOutput("d2 hold out_data", {24'd0, out_data2}, 32'h99);
        end
        in_valid2 = 1'b0;
        out_ready2 = 1'b1;
        stepCycle();
        out_ready2 = 1'b0;
        checkOutput("d2 out_valid after handshake", {31'd0, out_valid2}, 0);
        checkOutput("d2 busy after handshake", {31'd0, busy2}, 0);
        checkOutput("d2 in_ready after handshake", {31'd0, in_ready2}, 1);
`ifdef MSKUNSHARE_ZEROIZE_EN
        checkOutput("d2 zeroized out_data", {24'd0, out_data2}, 0);
        checkOutput("d2 zeroized sreg", {16'd0, u2.sreg_q}, 0);
`else
        checkOutput("d2 retained out_data", {24'd0, out_data2}, 32'h99);
        checkOutput("d2 retained sreg", {16'd0, u2.sreg_q}, {16'd0, pack2(8'h5A, 8'hC3)});
`endif
        stepCycle(); stepCycle(); stepCycle();
        checkOutput("d2 pulsed input not stored", {31'd0, busy2}, 0);

        // D=2 back-to-back: in_valid and out_ready held high
        out_ready2 = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, va[i], vb[i], 8'h00, ve[i], 1'b1, t);
            if (i > 0) checkOutput("d2 back-to-back interval", t - prev, 4);
            prev = t;
        end
        in_valid2 = 1'b0;
        guard = 0;
        while (q2.size() != 0 && guard < 20) begin
            stepCycle();
            guard++;
        end
        out_ready2 = 1'b0;

        // D=3: (0xFF, 0x0F, 0x33) -> 0xC3 three cycles after accept
        applyStimulus(1'b1, 8'hFF, 8'h0F, 8'h33, 8'hC3, 1'b1, t);
        in_valid3 = 1'b0;
        checkOutput("d3 busy at t", {31'd0, busy3}, 1);
        checkOutput("d3 out_valid at t", {31'd0, out_valid3}, 0);
        for (int k = 1; k <= 2; k++) begin
            stepCycle();
            checkOutput("d3 busy in fold", {31'd0, busy3}, 1);
            checkOutput("d3 out_valid in fold", {31'd0, out_valid3}, 0);
        end
        stepCycle();
        checkOutput("d3 out_valid at t+3", {31'd0, out_valid3}, 1);
        checkOutput("d3 out_data at t+3", {24'd0, out_data3}, 32'hC3);
        checkOutput("d3 busy at t+3", {31'd0, busy3}, 1);
        stepCycle();
        checkOutput("d3 busy after handshake", {31'd0, busy3}, 0);
        checkOutput("d3 out_valid after handshake", {31'd0, out_valid3}, 0);

        // D=3: reset during the second FOLD cycle aborts the sharing
        applyStimulus(1'b1, 8'h11, 8'h22, 8'h44, 8'h77, 1'b0, t);
        in_valid3 = 1'b0;
        stepCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("d3 in_ready during reset", {31'd0, in_ready3}, 0);
        stepCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("d3 out_valid after mid-fold reset", {31'd0, out_valid3}, 0);
        checkOutput("d3 out_data after mid-fold reset", {24'd0, out_data3}, 0);
        checkOutput("d3 in_ready after mid-fold reset", {31'd0, in_ready3}, 1);
        checkOutput("d3 busy after mid-fold reset", {31'd0, busy3}, 0);

        // New sharing after the abort: (0x01, 0x02, 0x04) -> 0x07
        applyStimulus(1'b1, 8'h01, 8'h02, 8'h04, 8'h07, 1'b1, t);
        in_valid3 = 1'b0;
        guard = 0;
        while (out_valid3 !== 1'b1 && guard < 20) begin
            stepCycle();
            guard++;
        end
        checkOutput("d3 post-reset out_valid", {31'd0, out_valid3}, 1);
        checkOutput("d3 post-reset latency", cycle - t, 3);
        checkOutput("d3 post-reset out_data", {24'd0, out_data3}, 32'h07);
        stepCycle();
        stepCycle();

        checkOutput("dut2 scoreboard drained", q2.size(), 0);
        checkOutput("dut3 scoreboard drained", q3.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/msk_unshare_serial.md
Name: msk_unshare_serial

Overview:
- Output-side decoder for masked datapaths: accepts a d-share Boolean sharing from masked gadgets and recombines it into the unmasked value.
- Mirror of the input-side share encoder.
- Recombination is serial: one share is folded per cycle from registered shares, so no combinational XOR tree ever sees all shares at once.
- Sits between the last masked stage (e.g. a Toffoli/AND gadget output register) and the plaintext output interface.

Parameters:
- d, 2, number of shares (d >= 2)
- W, 8, unmasked data width in bits

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- in_sh  input  d*W  input sharing, bit-major: shares of bit i at [i*d +: d], share j at index i*d+j
- in_valid  input  1  in_sh valid
- in_ready  output  1  block can accept a sharing
- out_data  output  W  recombined unmasked value
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- busy  output  1  high whenever state != IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: in_ready=0 during reset and 1 in the cycle after; out_valid=0; out_data=0; busy=0; share register=0; cnt=0; state=IDLE.
- States: IDLE, FOLD, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: copy in_sh into the share register sreg, set cnt=0, go to FOLD.
  - No output logic reads in_sh directly.
- FOLD:
  - in_ready=0.
  - cnt=0: acc <= share 0 of each bit.
  - cnt=k (1..d-1): acc <= acc ^ share k of each bit.
  - cnt increments each cycle.
  - After folding share d-1, go to HOLD with out_data=acc and out_valid=1.
- Latency: handshake at edge t leads to out_valid=1 after edge t+d (d FOLD cycles).
- HOLD:
  - out_valid=1; out_data is stable until accepted.
  - On out_ready: out_valid <= 0, go to IDLE.
  - There is no pass-through; the next input can be accepted from the cycle after the output handshake.
  - Minimum initiation interval is d+2 cycles.
- out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored (in_ready=0), and the input is not stored.
- cnt width is clog2(d); cnt wraps to 0 on leaving FOLD.
- rst_n=0 in any state, including mid-FOLD, forces the reset values at the next edge. A partial accumulator is never presented.
- d=2 gives 2 FOLD cycles; share indexing must be correct for any d up to 8.

Optional Feature:
- Macro: MSKUNSHARE_ZEROIZE_EN.
- Defined:
  - sreg is cleared to 0 on the edge leaving FOLD.
  - acc/out_data are cleared to 0 on the output handshake.
  - out_data reads 0 whenever out_valid=0, so no stale unmasked value or share remains in registers.
- Undefined:
  - sreg and out_data retain their last values until overwritten.
  - This saves the clear muxes.

Test Plan:
- d=2, W=8, in_sh shares (0x5A, 0xC3) in bit-major packing -> out_valid exactly 2 cycles after the accept edge; out_data=0x99.
- d=3, shares (0xFF, 0x0F, 0x33) -> out_data=0xC3, latency 3 cycles, busy high from the accept edge until the output handshake.
- out_ready held low 5 cycles in HOLD -> out_valid and out_data=0x99 stable; in_ready=0 with in_valid=1 pulsed; the later output is unchanged.
- rst_n low for one cycle at the second FOLD cycle (d=3) -> next cycle out_valid=0, out_data=0, in_ready=1; a new sharing (0x01, 0x02, 0x04) gives 0x07.
- Back-to-back with in_valid always high and out_ready always high (d=2) -> one output every 4 cycles, in order, values match the XOR of shares.
- With MSKUNSHARE_ZEROIZE_EN: after the output handshake, out_data=0 and sreg=0 (probed); without it, out_data keeps 0x99.
